// File: rtl/core_sequencer_if.sv
// rtl/core_sequencer_if.sv - handshake and control bundle between core_sequencer and the datapath/memories
// Purpose: groups every non-clock/reset signal of the sequencer.
// Ports (master = sequencer side):
//   in : instruction[31:0], imem_ready, dmem_ready, branch_taken
//   out: imem_req, ir_load, mem_req, mem_we, alu_src_imm, reg_write, wb_sel[1:0],
//        pc_write, pc_src[1:0], trap, trap_cause[1:0], instret[63:0]
interface core_sequencer_if;
  logic [31:0] instruction;
  logic        imem_ready;
  logic        dmem_ready;
  logic        branch_taken;
  logic        imem_req;
  logic        ir_load;
  logic        mem_req;
  logic        mem_we;
  logic        alu_src_imm;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [63:0] instret;

  modport master (
    input  instruction, imem_ready, dmem_ready, branch_taken,
    output imem_req, ir_load, mem_req, mem_we, alu_src_imm, reg_write,
           wb_sel, pc_write, pc_src, trap, trap_cause, instret
  );

  modport slave (
    output instruction, imem_ready, dmem_ready, branch_taken,
    input  imem_req, ir_load, mem_req, mem_we, alu_src_imm, reg_write,
           wb_sel, pc_write, pc_src, trap, trap_cause, instret
  );
endinterface

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control FSM for the rv64 core
// Purpose: sequences instruction fetch, decode, execute, data access and writeback,
//   traps stickily on illegal opcodes or memory timeouts, counts retired instructions.
// Ports:
//   clk  - core clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - core_sequencer_if.master (memory handshakes, datapath strobes, trap, instret)
module core_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  core_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_OP, C_OP_IMM, C_OP32, C_OP_IMM32, C_LOAD, C_STORE,
    C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILLEGAL
  } iclass_t;

  // Strobes that depend only on the state being entered; registered so they
  // change on the clock edge and clear directly on reset.
  typedef struct packed {
    logic       imem_req;
    logic       mem_req;
    logic       mem_we;
    logic       alu_src_imm;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       trap;
  } moore_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  function automatic iclass_t classify(input logic [6:0] opcode);
    iclass_t c;
    case (opcode)
      7'b0110011: c = C_OP;
      7'b0010011: c = C_OP_IMM;
      7'b0111011: c = C_OP32;
      7'b0011011: c = C_OP_IMM32;
      7'b0000011: c = C_LOAD;
      7'b0100011: c = C_STORE;
      7'b1100011: c = C_BRANCH;
      7'b1101111: c = C_JAL;
      7'b1100111: c = C_JALR;
      7'b0110111: c = C_LUI;
      7'b0010111: c = C_AUIPC;
      default:    c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  function automatic moore_t moore_for(input state_t s, input iclass_t c, input logic rd_nz);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH: m.imem_req = 1'b1;
      S_EXEC: begin
        m.alu_src_imm = !(c == C_OP || c == C_OP32 || c == C_BRANCH);
        m.pc_write    = (c == C_BRANCH);
      end
      S_MEM: begin
        m.mem_req     = 1'b1;
        m.mem_we      = (c == C_STORE);
        m.alu_src_imm = 1'b1;   // keep the address computation stable
      end
      S_WB: begin
        m.reg_write = rd_nz;
        m.pc_write  = 1'b1;
        case (c)
          C_LOAD:         m.wb_sel = 2'd1;
          C_JAL, C_JALR:  m.wb_sel = 2'd2;
          default:        m.wb_sel = 2'd0;
        endcase
        case (c)
          C_JAL:   m.pc_src = 2'd1;
          C_JALR:  m.pc_src = 2'd2;
          default: m.pc_src = 2'd0;
        endcase
      end
      S_TRAP:  m.trap = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  state_t           state, state_nxt;
  iclass_t          cls, cls_nxt, dec_cls;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       cause, cause_nxt;
  logic             retire;
  logic             rd_nz;
  logic             store_done;
  moore_t           mo, mo_nxt;
  logic [63:0]      instret;
  logic             unused_instr_bits;

  assign dec_cls           = classify(bus.instruction[6:0]);
  assign rd_nz             = (bus.instruction[11:7] != 5'd0);
  assign unused_instr_bits = ^bus.instruction[31:12];

  always_comb begin
    state_nxt = state;
    cls_nxt   = cls;
    cnt_nxt   = '0;
    cause_nxt = cause;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        // ready wins even on the last allowed wait cycle
        if (bus.imem_ready) begin
          state_nxt = S_DECODE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'd2;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DECODE: begin
        cls_nxt = dec_cls;
        if (dec_cls == C_ILLEGAL) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'd1;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: state_nxt = S_MEM;
          C_BRANCH: begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
          end
          default: state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          if (cls == C_STORE) begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
          end else begin
            state_nxt = S_WB;
          end
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'd3;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
    mo_nxt = moore_for(state_nxt, cls_nxt, rd_nz);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      cls     <= C_ILLEGAL;
      cnt     <= '0;
      cause   <= 2'd0;
      mo      <= moore_for(S_FETCH, C_ILLEGAL, 1'b0);
      instret <= 64'd0;
    end else begin
      state   <= state_nxt;
      cls     <= cls_nxt;
      cnt     <= cnt_nxt;
      cause   <= cause_nxt;
      mo      <= mo_nxt;
      instret <= instret + 64'(retire);
    end
  end

  // Outputs that react to a same-cycle input (ready or branch result).
  assign store_done = (state == S_MEM) && (cls == C_STORE) && bus.dmem_ready;

  assign bus.ir_load     = mo.imem_req & bus.imem_ready;
  assign bus.pc_write    = mo.pc_write | store_done;
  assign bus.pc_src      = (state == S_EXEC && cls == C_BRANCH) ? {1'b0, bus.branch_taken} : mo.pc_src;
  assign bus.imem_req    = mo.imem_req;
  assign bus.mem_req     = mo.mem_req;
  assign bus.mem_we      = mo.mem_we;
  assign bus.alu_src_imm = mo.alu_src_imm;
  assign bus.reg_write   = mo.reg_write;
  assign bus.wb_sel      = mo.wb_sel;
  assign bus.trap        = mo.trap;
  assign bus.trap_cause  = cause;
  assign bus.instret     = instret;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - self-checking bench for core_sequencer
module tb_core_sequencer;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic       imem_req;
    logic       ir_load;
    logic       mem_req;
    logic       mem_we;
    logic       alu_src_imm;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       trap;
    logic [1:0] trap_cause;
  } outs_t;

  logic        clk;
  logic        rst;
  logic [31:0] cur_instr;
  logic [63:0] exp_instret;
  int          n_checks;
  int          n_pass;
  int          n_fail;

  core_sequencer_if bus();

  core_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t observe();
    outs_t o;
    o.imem_req    = bus.imem_req;
    o.ir_load     = bus.ir_load;
    o.mem_req     = bus.mem_req;
    o.mem_we      = bus.mem_we;
    o.alu_src_imm = bus.alu_src_imm;
    o.reg_write   = bus.reg_write;
    o.wb_sel      = bus.wb_sel;
    o.pc_write    = bus.pc_write;
    o.pc_src      = bus.pc_src;
    o.trap        = bus.trap;
    o.trap_cause  = bus.trap_cause;
    return o;
  endfunction

  function automatic string cls_of(input logic [6:0] opc);
    case (opc)
      7'b0110011: return "op";
      7'b0010011: return "opimm";
      7'b0111011: return "op32";
      7'b0011011: return "opimm32";
      7'b0000011: return "load";
      7'b0100011: return "store";
      7'b1100011: return "branch";
      7'b1101111: return "jal";
      7'b1100111: return "jalr";
      7'b0110111: return "lui";
      7'b0010111: return "auipc";
      default:    return "illegal";
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge: drive, settle, compare, move to the next falling edge.
  task automatic step(input string tag, input logic ir, input logic dr, input logic bt, input outs_t e);
    bus.instruction  = cur_instr;
    bus.imem_ready   = ir;
    bus.dmem_ready   = dr;
    bus.branch_taken = bt;
    #1;
    chk($sformatf("%s/outs[%08h]", tag, cur_instr), {50'd0, observe()}, {50'd0, e});
    chk($sformatf("%s/instret[%08h]", tag, cur_instr), bus.instret, exp_instret);
    @(negedge clk);
  endtask

  task automatic do_reset();
    outs_t e;
    rst              = 1'b1;
    bus.imem_ready   = 1'b0;
    bus.dmem_ready   = 1'b0;
    bus.branch_taken = 1'b0;
    @(negedge clk);
    #1;
    e = '0;
    e.imem_req = 1'b1;
    chk("reset/outs", {50'd0, observe()}, {50'd0, e});
    chk("reset/instret", bus.instret, 64'd0);
    @(negedge clk);
    rst         = 1'b0;
    exp_instret = 64'd0;
  endtask

  task automatic trap_hold(input logic [1:0] cause, input int n);
    outs_t e;
    e = '0;
    e.trap       = 1'b1;
    e.trap_cause = cause;
    for (int i = 0; i < n; i++) step("trap", 1'b1, rb(), rb(), e);
  endtask

  // Reference: expected per-cycle strobes of one instruction from its class,
  // fetch wait count fw, data wait count mw and the branch outcome.
  task automatic run_instr(input logic [31:0] instr, input int fw, input int mw, input logic bt);
    outs_t e;
    string c;
    int    nf;
    int    nm;
    cur_instr = instr;
    c  = cls_of(instr[6:0]);
    e  = '0;
    e.imem_req = 1'b1;
    nf = (fw < TIMEOUT) ? fw : TIMEOUT;
    for (int i = 0; i < nf; i++) step("fetch_wait", 1'b0, rb(), rb(), e);
    if (fw >= TIMEOUT) begin
      trap_hold(2'd2, 3);
      return;
    end
    e.ir_load = 1'b1;
    step("fetch", 1'b1, rb(), rb(), e);
    e = '0;
    step("decode", rb(), rb(), rb(), e);
    if (c == "illegal") begin
      trap_hold(2'd1, 20);
      return;
    end
    e.alu_src_imm = !(c == "op" || c == "op32" || c == "branch");
    if (c == "branch") begin
      e.pc_write = 1'b1;
      e.pc_src   = {1'b0, bt};
      step("exec", rb(), rb(), bt, e);
      exp_instret++;
      return;
    end
    step("exec", rb(), rb(), rb(), e);
    if (c == "load" || c == "store") begin
      e = '0;
      e.mem_req     = 1'b1;
      e.mem_we      = (c == "store");
      e.alu_src_imm = 1'b1;
      nm = (mw < TIMEOUT) ? mw : TIMEOUT;
      for (int i = 0; i < nm; i++) step("mem_wait", rb(), 1'b0, rb(), e);
      if (mw >= TIMEOUT) begin
        trap_hold(2'd3, 3);
        return;
      end
      if (c == "store") e.pc_write = 1'b1;
      step("mem", rb(), 1'b1, rb(), e);
      if (c == "store") begin
        exp_instret++;
        return;
      end
    end
    e = '0;
    e.reg_write = (instr[11:7] != 5'd0);
    e.pc_write  = 1'b1;
    e.wb_sel    = (c == "load") ? 2'd1 : ((c == "jal" || c == "jalr") ? 2'd2 : 2'd0);
    e.pc_src    = (c == "jal") ? 2'd1 : ((c == "jalr") ? 2'd2 : 2'd0);
    step("wb", rb(), rb(), rb(), e);
    exp_instret++;
  endtask

  initial begin
    outs_t       e;
    logic [6:0]  opcodes [11];
    logic [31:0] r;
    logic [31:0] instr;
    int          idx;

    opcodes = '{7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    n_checks         = 0;
    n_pass           = 0;
    n_fail           = 0;
    exp_instret      = 64'd0;
    cur_instr        = 32'd0;
    rst              = 1'b1;
    bus.instruction  = 32'd0;
    bus.imem_ready   = 1'b0;
    bus.dmem_ready   = 1'b0;
    bus.branch_taken = 1'b0;

    do_reset();

    // reset while a load waits in MEM: request drops at once, nothing retires
    cur_instr = 32'h0002A283;
    e = '0; e.imem_req = 1'b1; e.ir_load = 1'b1;
    step("fetch", 1'b1, 1'b0, 1'b0, e);
    e = '0;
    step("decode", 1'b0, 1'b0, 1'b0, e);
    e.alu_src_imm = 1'b1;
    step("exec", 1'b0, 1'b0, 1'b0, e);
    e = '0; e.mem_req = 1'b1; e.alu_src_imm = 1'b1;
    step("mem_wait", 1'b0, 1'b0, 1'b0, e);
    #2;
    rst = 1'b1;
    #1;
    chk("midmem_rst/mem_req", {63'd0, bus.mem_req}, 64'd0);
    chk("midmem_rst/imem_req", {63'd0, bus.imem_req}, 64'd1);
    chk("midmem_rst/instret", bus.instret, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    run_instr(32'h00100093, 0, 0, 1'b0);   // ADDI x1
    run_instr(32'h00000463, 0, 0, 1'b1);   // BEQ taken
    run_instr(32'h00000463, 1, 0, 1'b0);   // BEQ not taken
    run_instr(32'h0002A283, 0, 3, 1'b0);   // LW x5, 3 wait cycles
    run_instr(32'h0051A023, 2, 1, 1'b0);   // SW
    run_instr(32'h0000006F, 0, 0, 1'b0);   // JAL x0
    run_instr(32'h00100093, TIMEOUT - 1, 0, 1'b0);   // fetch ready on last wait cycle
    run_instr(32'h0002A283, 0, TIMEOUT - 1, 1'b0);   // data ready on last wait cycle

    // randomized legal instructions
    for (int k = 0; k < 40; k++) begin
      idx   = $urandom_range(0, 10);
      r     = $urandom();
      instr = {r[31:7], opcodes[idx]};
      run_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3), rb());
    end
    e = '0; e.imem_req = 1'b1;
    step("final_fetch", 1'b0, 1'b0, 1'b0, e);

    // illegal opcode: sticky through 20 cycles of imem_ready
    run_instr(32'h0000007F, 0, 0, 1'b0);
    do_reset();

    // imem timeout
    run_instr(32'h00100093, TIMEOUT, 0, 1'b0);
    do_reset();

    // dmem timeout
    run_instr(32'h0002A283, 0, TIMEOUT, 1'b0);
    do_reset();

    run_instr(32'h00100093, 0, 0, 1'b0);
    e = '0; e.imem_req = 1'b1;
    step("post_reset_fetch", 1'b0, 1'b0, 1'b0, e);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
